flag_ctrl: RTL and testbench
============================

Name: flag_ctrl

Overview:
- Owns the live C and Z status flags of the RAT CPU, plus a LIFO shadow stack that saves the flags on interrupt entry and restores them on RETIE, with nesting up to DEPTH levels.
- Sits between the ALU outputs and the control unit.
- Provides the registered flag values and a branch-condition decode (BR_TAKE) that the PC-load logic reads.

Parameters:
- DEPTH, 4, number of shadow stack entries (1..16); each entry holds {C,Z}.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- RST_N  in  1  synchronous, active-low reset; sampled on the rising clk edge
- C_IN  in  1  carry result from the ALU
- Z_IN  in  1  zero result from the ALU
- FLG_C_LD  in  1  load C_FLAG from C_IN
- FLG_Z_LD  in  1  load Z_FLAG from Z_IN
- FLG_C_SET  in  1  force C_FLAG=1 (SEC)
- FLG_C_CLR  in  1  force C_FLAG=0 (CLC)
- FLG_SAVE  in  1  interrupt entry: push {C_FLAG,Z_FLAG}
- FLG_RESTORE  in  1  RETIE: pop into {C_FLAG,Z_FLAG}
- BR_COND  in  3  branch condition select
- C_FLAG  out  1  registered carry flag
- Z_FLAG  out  1  registered zero flag
- BR_TAKE  out  1  combinational branch decision from the registered flags
- SHAD_DEPTH  out  $clog2(DEPTH+1)  current number of stacked entries
- SHAD_FULL  out  1  SHAD_DEPTH==DEPTH
- SHAD_EMPTY  out  1  SHAD_DEPTH==0
- SHAD_ERR  out  1  sticky error: overflow, underflow or save/restore collision

Behaviour:
- Reset (RST_N=0 at an edge):
  - C_FLAG=0, Z_FLAG=0, SHAD_DEPTH=0, SHAD_ERR=0, all stack entries=0.
  - Reset overrides every other input.
  - Reset asserted mid-nest discards all saved entries.
- Flag update when no valid restore is occurring; changes are visible one cycle after the edge:
  - C_FLAG priority: FLG_C_CLR > FLG_C_SET > FLG_C_LD > hold.
  - Z_FLAG: FLG_Z_LD ? Z_IN : hold.
- Valid SAVE (FLG_SAVE=1, FLG_RESTORE=0, not full):
  - entry[SHAD_DEPTH] <= current registered {C_FLAG,Z_FLAG}, i.e. the pre-edge value.
  - SHAD_DEPTH increments.
  - Same-cycle flag loads still apply to the live flags, but do not affect the saved value.
- SAVE when full: no push, depth unchanged, SHAD_ERR<=1, live flags update normally.
- Valid RESTORE (FLG_RESTORE=1, FLG_SAVE=0, not empty):
  - {C_FLAG,Z_FLAG} <= entry[SHAD_DEPTH-1]; SHAD_DEPTH decrements.
  - Restore overrides all same-cycle LD/SET/CLR.
- RESTORE when empty: flags follow normal update rules, depth stays 0, SHAD_ERR<=1.
- FLG_SAVE and FLG_RESTORE both set: illegal.
  - No stack change, depth unchanged, SHAD_ERR<=1.
  - Flags follow normal update rules.
- SHAD_ERR clears only on reset.
- Stack entries above SHAD_DEPTH are don't-care and are never read.
- BR_TAKE is purely combinational from the registered flags (zero latency), so a branch sees the flags committed at the previous edge:
  - 000: 1 (BRN)
  - 001: Z_FLAG (BREQ)
  - 010: ~Z_FLAG (BRNE)
  - 011: C_FLAG (BRCS)
  - 100: ~C_FLAG (BRCC)
  - 101–111: 0
- SHAD_FULL and SHAD_EMPTY are combinational from SHAD_DEPTH.

Test Plan:
- Reset: hold RST_N=0 for 2 edges with all loads=1, C_IN=Z_IN=1 -> C_FLAG=0, Z_FLAG=0, SHAD_DEPTH=0, SHAD_EMPTY=1, SHAD_ERR=0. Then release RST_N -> next edge C=1, Z=1.
- Priority: C_IN=1, FLG_C_LD=1, FLG_C_SET=1, FLG_C_CLR=1 -> C_FLAG=0. Drop CLR -> C_FLAG=1. C_IN=0 with LD only -> C_FLAG=0. BR_COND=011/100 tracks C_FLAG with zero latency, and BR_COND=110 gives 0.
- Nesting: set {C,Z}={1,0}, SAVE; set {0,1}, SAVE; set {1,1} -> depth=2. RESTORE -> {0,1}, depth 1. RESTORE -> {1,0}, depth 0, SHAD_ERR=0.
- Save with load: {C,Z}={0,0}, SAVE with FLG_Z_LD=1, Z_IN=1 -> Z_FLAG=1 live. RESTORE -> Z_FLAG=0.
- Overflow/underflow: DEPTH=4, 5 SAVEs -> depth=4, SHAD_FULL=1, SHAD_ERR=1. Reset, then RESTORE on empty -> depth 0, SHAD_ERR=1, flags unchanged.
- Collision and reset mid-nest: depth 1, SAVE+RESTORE same cycle -> depth 1, SHAD_ERR=1. RESTORE with FLG_C_SET=1 -> saved C wins. Depth 3, then RST_N=0 -> depth 0, flags 0.

Source files
------------

// File: rtl/flag_ctrl.sv
// Live C/Z status flags for the RAT CPU with a LIFO shadow stack that saves
// the flags on interrupt entry and restores them on RETIE, plus branch decode.
module flag_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         RST_N,
  input  logic                         C_IN,
  input  logic                         Z_IN,
  input  logic                         FLG_C_LD,
  input  logic                         FLG_Z_LD,
  input  logic                         FLG_C_SET,
  input  logic                         FLG_C_CLR,
  input  logic                         FLG_SAVE,
  input  logic                         FLG_RESTORE,
  input  logic [2:0]                   BR_COND,
  output logic                         C_FLAG,
  output logic                         Z_FLAG,
  output logic                         BR_TAKE,
  output logic [$clog2(DEPTH+1)-1:0]   SHAD_DEPTH,
  output logic                         SHAD_FULL,
  output logic                         SHAD_EMPTY,
  output logic                         SHAD_ERR
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] DEPTH_V = DW'(DEPTH);

  // Each entry packs {C,Z}.
  logic [1:0]    stack_q [DEPTH];
  logic [DW-1:0] depth_q;
  logic          c_q, z_q, err_q;

  logic          full, empty;
  logic          do_save, do_restore, err_evt;
  logic [AW-1:0] push_idx, pop_idx;
  logic [1:0]    pop_val;
  logic          c_nxt, z_nxt;

  assign full  = (depth_q == DEPTH_V);
  assign empty = (depth_q == '0);

  assign do_save    = FLG_SAVE & ~FLG_RESTORE & ~full;
  assign do_restore = FLG_RESTORE & ~FLG_SAVE & ~empty;
  assign err_evt    = (FLG_SAVE & FLG_RESTORE)
                    | (FLG_SAVE & ~FLG_RESTORE & full)
                    | (FLG_RESTORE & ~FLG_SAVE & empty);

  // Index is only used when the push/pop is legal, so truncation is safe.
  assign push_idx = AW'(depth_q);
  assign pop_idx  = AW'(depth_q - DW'(1));
  assign pop_val  = stack_q[pop_idx];

  always_comb begin
    c_nxt = c_q;
    z_nxt = z_q;
    if (do_restore) begin
      c_nxt = pop_val[1];
      z_nxt = pop_val[0];
    end else begin
      if (FLG_C_CLR)      c_nxt = 1'b0;
      else if (FLG_C_SET) c_nxt = 1'b1;
      else if (FLG_C_LD)  c_nxt = C_IN;
      if (FLG_Z_LD)       z_nxt = Z_IN;
    end
  end

  always_ff @(posedge clk) begin
    if (!RST_N) begin
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      err_q   <= 1'b0;
      depth_q <= '0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= 2'b00;
    end else begin
      c_q <= c_nxt;
      z_q <= z_nxt;
      if (err_evt) err_q <= 1'b1;
      if (do_save) begin
        // Saved value is the pre-edge flag state, not this cycle's loads.
        stack_q[push_idx] <= {c_q, z_q};
        depth_q           <= depth_q + DW'(1);
      end else if (do_restore) begin
        depth_q <= depth_q - DW'(1);
      end
    end
  end

  always_comb begin
    BR_TAKE = 1'b0;
    case (BR_COND)
      3'b000:  BR_TAKE = 1'b1;
      3'b001:  BR_TAKE = z_q;
      3'b010:  BR_TAKE = ~z_q;
      3'b011:  BR_TAKE = c_q;
      3'b100:  BR_TAKE = ~c_q;
      default: BR_TAKE = 1'b0;
    endcase
  end

  assign C_FLAG     = c_q;
  assign Z_FLAG     = z_q;
  assign SHAD_DEPTH = depth_q;
  assign SHAD_FULL  = full;
  assign SHAD_EMPTY = empty;
  assign SHAD_ERR   = err_q;

endmodule

// File: tb/tb_flag_ctrl.sv
// Bench for flag_ctrl: directed scenarios plus random traffic, compared
// against a queue-based model of the flag/shadow-stack rules.
module tb_flag_ctrl;

  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          c_in, z_in, c_ld, z_ld, c_set, c_clr, save, restore;
  logic [2:0]    br_cond;
  logic          c_flag, z_flag, br_take, shad_full, shad_empty, shad_err;
  logic [DW-1:0] shad_depth;

  // Reference model state
  logic [1:0] shad_q[$];
  logic       m_c, m_z, m_err;

  int n_checks = 0;
  int n_pass   = 0;

  flag_ctrl #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .RST_N       (rst_n),
    .C_IN        (c_in),
    .Z_IN        (z_in),
    .FLG_C_LD    (c_ld),
    .FLG_Z_LD    (z_ld),
    .FLG_C_SET   (c_set),
    .FLG_C_CLR   (c_clr),
    .FLG_SAVE    (save),
    .FLG_RESTORE (restore),
    .BR_COND     (br_cond),
    .C_FLAG      (c_flag),
    .Z_FLAG      (z_flag),
    .BR_TAKE     (br_take),
    .SHAD_DEPTH  (shad_depth),
    .SHAD_FULL   (shad_full),
    .SHAD_EMPTY  (shad_empty),
    .SHAD_ERR    (shad_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic br_model(input logic [2:0] cond, input logic c, input logic z);
    case (cond)
      3'd0:    return 1'b1;
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return c;
      3'd4:    return !c;
      default: return 1'b0;
    endcase
  endfunction

  // Advance the model by one edge using the current inputs, then clock the DUT.
  task automatic tick();
    int   sz;
    logic save_ok, rest_ok;
    logic [1:0] top;
    sz = shad_q.size();
    if (!rst_n) begin
      m_c = 1'b0; m_z = 1'b0; m_err = 1'b0;
      shad_q.delete();
    end else begin
      save_ok = save && !restore && (sz < DEPTH);
      rest_ok = restore && !save && (sz > 0);
      if ((save && restore) || (save && sz == DEPTH) || (restore && sz == 0)) m_err = 1'b1;
      if (rest_ok) begin
        top = shad_q.pop_back();
        m_c = top[1];
        m_z = top[0];
      end else begin
        if (save_ok) shad_q.push_back({m_c, m_z});
        if (c_clr)      m_c = 1'b0;
        else if (c_set) m_c = 1'b1;
        else if (c_ld)  m_c = c_in;
        if (z_ld) m_z = z_in;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".c"},     32'(c_flag),     32'(m_c));
    check({tag, ".z"},     32'(z_flag),     32'(m_z));
    check({tag, ".depth"}, 32'(shad_depth), 32'(shad_q.size()));
    check({tag, ".full"},  32'(shad_full),  32'(shad_q.size() == DEPTH));
    check({tag, ".empty"}, 32'(shad_empty), 32'(shad_q.size() == 0));
    check({tag, ".err"},   32'(shad_err),   32'(m_err));
    check({tag, ".br"},    32'(br_take),    32'(br_model(br_cond, m_c, m_z)));
  endtask

  task automatic idle();
    c_in = 0; z_in = 0; c_ld = 0; z_ld = 0; c_set = 0; c_clr = 0;
    save = 0; restore = 0;
  endtask

  task automatic set_flags(input logic c, input logic z);
    idle();
    c_ld = 1; z_ld = 1; c_in = c; z_in = z;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; br_cond = 3'd0;
    idle();

    // Reset overrides loads
    c_ld = 1; z_ld = 1; c_in = 1; z_in = 1;
    tick(); tick();
    check_state("reset");
    check("reset.c_lit", 32'(c_flag), 0);
    check("reset.empty_lit", 32'(shad_empty), 1);
    rst_n = 1;
    tick();
    check_state("release");
    check("release.cz_lit", 32'({c_flag, z_flag}), 32'h3);

    // C priority
    idle();
    c_in = 1; c_ld = 1; c_set = 1; c_clr = 1; tick();
    check("prio.clr", 32'(c_flag), 0);
    c_clr = 0; tick();
    check("prio.set", 32'(c_flag), 1);
    c_set = 0; c_in = 0; tick();
    check("prio.ld", 32'(c_flag), 0);
    idle();
    br_cond = 3'b011; #1 check("br.cs0", 32'(br_take), 0);
    br_cond = 3'b100; #1 check("br.cc0", 32'(br_take), 1);
    c_set = 1; tick(); idle();
    br_cond = 3'b011; #1 check("br.cs1", 32'(br_take), 1);
    br_cond = 3'b100; #1 check("br.cc1", 32'(br_take), 0);
    br_cond = 3'b110; #1 check("br.rsv", 32'(br_take), 0);
    check_state("prio");

    // Nesting
    set_flags(1, 0); save = 1; tick(); idle();
    set_flags(0, 1); save = 1; tick(); idle();
    set_flags(1, 1);
    check_state("nest.d2");
    check("nest.d2_lit", 32'(shad_depth), 2);
    restore = 1; tick(); idle();
    check_state("nest.r1");
    check("nest.r1_lit", 32'({c_flag, z_flag}), 32'h1);
    restore = 1; tick(); idle();
    check_state("nest.r0");
    check("nest.r0_lit", 32'({c_flag, z_flag, shad_err}), 32'h4);

    // Save with simultaneous load
    set_flags(0, 0);
    save = 1; z_ld = 1; z_in = 1; tick(); idle();
    check_state("saveld");
    restore = 1; tick(); idle();
    check_state("saveld.r");
    check("saveld.z_lit", 32'(z_flag), 0);

    // Overflow
    for (int i = 0; i < 5; i++) begin
      save = 1; tick();
    end
    idle();
    check_state("ovf");
    check("ovf.lit", 32'({shad_depth, shad_full, shad_err}), 32'({3'd4, 1'b1, 1'b1}));

    // Underflow
    do_reset();
    set_flags(1, 0);
    restore = 1; tick(); idle();
    check_state("udf");

    // Collision, restore beats set, reset mid-nest
    do_reset();
    set_flags(0, 1);
    save = 1; tick(); idle();
    save = 1; restore = 1; tick(); idle();
    check_state("coll");
    set_flags(1, 0);
    restore = 1; c_set = 1; tick(); idle();
    check_state("rst_set");
    check("rst_set.c_lit", 32'(c_flag), 0);
    for (int i = 0; i < 3; i++) begin
      set_flags(i[0], 1); save = 1; tick(); idle();
    end
    check_state("mid.d3");
    do_reset();
    check_state("mid.rst");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst_n   = ($urandom_range(0, 59) != 0);
      c_in    = 1'($urandom_range(0, 1));
      z_in    = 1'($urandom_range(0, 1));
      c_ld    = 1'($urandom_range(0, 1));
      z_ld    = 1'($urandom_range(0, 1));
      c_set   = ($urandom_range(0, 5) == 0);
      c_clr   = ($urandom_range(0, 5) == 0);
      save    = ($urandom_range(0, 3) == 0);
      restore = ($urandom_range(0, 3) == 0);
      br_cond = 3'($urandom_range(0, 7));
      tick();
      check_state("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
